inta_sequencer: RTL and testbench
=================================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 Parameter PULSE_CYCLES, default 2: INTA low width per pulse, in clocks; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 2: INTA high width between the two pulses, in clocks; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: INT-release watchdog limit, in clocks.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 INT  in  1  interrupt request from the PIC.
REQ-007 IF_enable  in  1  CPU interrupt-enable flag.
REQ-008 data_bus  in  8  vector byte driven by the PIC during the second INTA pulse.
REQ-009 vector_taken  in  1  core accepts the presented vector.
REQ-010 INTA  out  1  active-low interrupt acknowledge to the PIC.
REQ-011 vector  out  8  captured interrupt vector.
REQ-012 vector_valid  out  1  vector is held stable until taken.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 timeout_err  out  1  sticky watchdog flag.

Function
REQ-015 The FSM SHALL have the states IDLE, ACK1, GAP, ACK2, HOLD and WAIT_RELEASE.
REQ-016 IDLE->ACK1 SHALL occur when INT=1 and IF_enable=1 are sampled on the same edge.
REQ-017 INTA SHALL be 0 only in ACK1 and ACK2, each for exactly PULSE_CYCLES clocks, and SHALL be 1 in GAP for exactly GAP_CYCLES clocks.
REQ-018 Latency: with INT sampled high at edge N, INTA SHALL be low in cycles N+1..N+P, high in N+P+1..N+P+G, and low in N+P+G+1..N+2P+G; vector_valid SHALL rise at N+2P+G+1.
REQ-019 vector SHALL load data_bus on the last ACK2 cycle; the FSM then moves to HOLD.
REQ-020 In HOLD, vector_valid=1 and vector SHALL remain stable; vector_taken=1 SHALL clear vector_valid on the next edge and move the FSM to WAIT_RELEASE.
REQ-021 vector_taken SHALL be ignored while vector_valid=0.
REQ-022 WAIT_RELEASE->IDLE SHALL occur when INT is sampled 0, so a single INT assertion cannot start two sequences.
REQ-023 Once a sequence has entered ACK1, it SHALL complete through HOLD even if INT or IF_enable drops; the vector captured is whatever the PIC drives (spurious vector).
REQ-024 Pulse and gap counters SHALL be 4 bits, reload on each state entry, and never wrap within a state.

Reset
REQ-025 On reset the block SHALL set state=IDLE, INTA=1, vector=8'h00, vector_valid=0, busy=0, timeout_err=0 and clear all counters, effective at the next edge.
REQ-026 Reset in any state, including mid-pulse, SHALL return INTA high at the next edge; no partial vector SHALL be presented.

Configuration
REQ-027 With macro INTA_TIMEOUT_EN defined, a WAIT_RELEASE dwell of TIMEOUT_CYCLES clocks without INT=0 SHALL set timeout_err, which stays set until reset, and SHALL force IDLE.
REQ-028 With INTA_TIMEOUT_EN undefined, timeout_err SHALL be tied 0, no watchdog counter SHALL exist, and WAIT_RELEASE SHALL wait indefinitely.

Structure
REQ-029 Shared package inta_pkg SHALL hold the state enum typedef, the default parameter constants and the counter width constant.
REQ-030 One sub-module, inta_pulse_timer, SHALL be used: a loadable 4-bit down-counter with a done flag, shared by ACK1, GAP and ACK2.

Verification
REQ-031 Defaults, INT=1 and IF_enable=1 at edge 0, data_bus=8'h4A during ACK2 -> INTA low in cycles 1-2 and 5-6, vector=8'h4A and vector_valid=1 at cycle 7.
REQ-032 INT=1 with IF_enable=0 for 20 cycles -> INTA stays 1 and busy stays 0.
REQ-033 vector_taken held 0 for 10 cycles in HOLD -> vector_valid and vector stable; a vector_taken pulse -> vector_valid=0 next edge; INT still 1 -> no new ACK1 until INT is seen 0.
REQ-034 Reset asserted in cycle 5, during ACK2 -> INTA=1, vector_valid=0 and vector=8'h00 at cycle 6.
REQ-035 With INTA_TIMEOUT_EN defined, INT held 1 after vector_taken -> timeout_err=1 exactly 64 cycles after WAIT_RELEASE entry, then IDLE; the flag persists until reset.
REQ-036 PULSE_CYCLES=1, GAP_CYCLES=1 -> single-cycle INTA pulses with a one-cycle gap; vector_valid at cycle 4.

Source files
------------

// File: rtl/inta_pkg.sv
// inta_pkg: shared types and constants for the interrupt-acknowledge sequencer.
//   inta_state_t        - sequencer FSM state encoding
//   *_CYCLES_DEF        - default timing parameters (clocks)
//   CNT_W               - width of the pulse/gap counter
//   reload_val()        - counter reload value for an N-clock dwell
package inta_pkg;

  localparam int PULSE_CYCLES_DEF   = 2;
  localparam int GAP_CYCLES_DEF     = 2;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int CNT_W              = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD,
    WAIT_RELEASE
  } inta_state_t;

  // The counter reaches zero on the last clock of the dwell, so an
  // N-clock dwell loads N-1.
  function automatic logic [CNT_W-1:0] reload_val(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/inta_if.sv
// inta_if: handshake bundle between the PIC/CPU side and the sequencer.
//   INT, IF_enable, data_bus, vector_taken : driven by the PIC/CPU (master)
//   INTA, vector, vector_valid, busy,
//   timeout_err                            : driven by the sequencer (slave)
interface inta_if;

  logic       INT;
  logic       IF_enable;
  logic [7:0] data_bus;
  logic       vector_taken;
  logic       INTA;
  logic [7:0] vector;
  logic       vector_valid;
  logic       busy;
  logic       timeout_err;

  modport master (
    output INT, IF_enable, data_bus, vector_taken,
    input  INTA, vector, vector_valid, busy, timeout_err
  );

  modport slave (
    input  INT, IF_enable, data_bus, vector_taken,
    output INTA, vector, vector_valid, busy, timeout_err
  );

endinterface

// File: rtl/inta_pulse_timer.sv
// inta_pulse_timer: loadable down-counter timing the ACK1, GAP and ACK2 dwells.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (takes priority over counting)
//   load_val   : reload value (dwell length minus one)
//   en         : count down while nonzero
//   done       : counter is at zero (last clock of the dwell)
module inta_pulse_timer
  import inta_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Saturates at zero so it can never wrap inside a state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer: generates the two-pulse INTA handshake to the PIC, captures
// the interrupt vector on the second pulse and holds it until the core takes it.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : inta_if.slave (INT, IF_enable, data_bus, vector_taken in;
//           INTA, vector, vector_valid, busy, timeout_err out)
// Parameters: PULSE_CYCLES (1..15), GAP_CYCLES (1..15), TIMEOUT_CYCLES.
// Build option: define INTA_TIMEOUT_EN to add the WAIT_RELEASE watchdog;
// without it timeout_err is tied low and WAIT_RELEASE waits indefinitely.
module inta_sequencer
  import inta_pkg::*;
#(
  parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic   clk,
  input  logic   reset,
  inta_if.slave  bus
);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15 || GAP_CYCLES < 1 ||
      GAP_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("inta_sequencer: timing parameter out of range");
  end

  inta_state_t      state;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_done;

  // The timer reloads on the same edge the FSM enters the timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: if (bus.INT && bus.IF_enable) begin
        tmr_load = 1'b1;
        tmr_val  = reload_val(PULSE_CYCLES);
      end
      ACK1: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = reload_val(GAP_CYCLES);
      end
      GAP: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = reload_val(PULSE_CYCLES);
      end
      default: ;
    endcase
  end

  assign tmr_en = (state == ACK1) || (state == GAP) || (state == ACK2);

  inta_pulse_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

`ifdef INTA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_count;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bus.INTA         <= 1'b1;
      bus.vector       <= 8'h00;
      bus.vector_valid <= 1'b0;
      bus.busy         <= 1'b0;
`ifdef INTA_TIMEOUT_EN
      bus.timeout_err  <= 1'b0;
      wd_count         <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.INT && bus.IF_enable) begin
          state    <= ACK1;
          bus.INTA <= 1'b0;
          bus.busy <= 1'b1;
        end
        // Once ACK1 is entered the sequence runs to HOLD regardless of INT.
        ACK1: if (tmr_done) begin
          state    <= GAP;
          bus.INTA <= 1'b1;
        end
        GAP: if (tmr_done) begin
          state    <= ACK2;
          bus.INTA <= 1'b0;
        end
        ACK2: if (tmr_done) begin
          state            <= HOLD;
          bus.INTA         <= 1'b1;
          bus.vector       <= bus.data_bus;
          bus.vector_valid <= 1'b1;
        end
        HOLD: if (bus.vector_taken) begin
          state            <= WAIT_RELEASE;
          bus.vector_valid <= 1'b0;
`ifdef INTA_TIMEOUT_EN
          wd_count         <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        // Wait for INT to drop so one request cannot start two sequences.
        WAIT_RELEASE: begin
          if (!bus.INT) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
`ifdef INTA_TIMEOUT_EN
          else if (wd_count == '0) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b1;
          end else begin
            wd_count <= wd_count - 1'b1;
          end
`endif
        end
        default: begin
          state            <= IDLE;
          bus.INTA         <= 1'b1;
          bus.vector_valid <= 1'b0;
          bus.busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: drives a default-timing sequencer and a 1/1-timing
// sequencer from the same stimulus and compares both against a time-based
// reference model of the INTA handshake.
module tb_inta_sequencer;

`ifdef INTA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       int_i = 1'b0;
  logic       if_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       taken_i = 1'b0;
  bit         rnd_data = 1'b0;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  inta_if bus_a ();
  inta_if bus_b ();

  assign bus_a.INT = int_i;          assign bus_b.INT = int_i;
  assign bus_a.IF_enable = if_i;     assign bus_b.IF_enable = if_i;
  assign bus_a.data_bus = data_i;    assign bus_b.data_bus = data_i;
  assign bus_a.vector_taken = taken_i; assign bus_b.vector_taken = taken_i;

  inta_sequencer dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(1), .TIMEOUT_CYCLES(TO))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // Reference model: phase 0 idle, 1 handshake running, 2 vector held,
  // 3 waiting for INT release. INTA is derived from elapsed time since start.
  int         mp[2] = '{2, 1};
  int         mg[2] = '{2, 1};
  int         m_phase[2];
  int         m_t0[2];
  int         m_rel[2];
  logic [7:0] m_vec[2];
  bit         m_err[2];

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = 0;
        m_vec[i]   = 8'h00;
        m_err[i]   = 1'b0;
      end else begin
        case (m_phase[i])
          0: if (int_i && if_i) begin m_phase[i] = 1; m_t0[i] = edge_n; end
          1: if (edge_n - m_t0[i] == 2 * mp[i] + mg[i]) begin
               m_vec[i] = data_i;
               m_phase[i] = 2;
             end
          2: if (taken_i) begin m_phase[i] = 3; m_rel[i] = edge_n; end
          default: if (!int_i) m_phase[i] = 0;
                   else if (TO_EN && (edge_n - m_rel[i] == TO)) begin
                     m_err[i] = 1'b1;
                     m_phase[i] = 0;
                   end
        endcase
      end
    end
  endtask

  function automatic logic exp_inta(input int i);
    int k;
    k = edge_n + 1 - m_t0[i];
    if (m_phase[i] == 1 &&
        ((k >= 1 && k <= mp[i]) ||
         (k >= mp[i] + mg[i] + 1 && k <= 2 * mp[i] + mg[i])))
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int i, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d edge=%0d observed=%h expected=%h",
             tag, i, edge_n, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] a_inta[2], a_vec[2], a_vv[2], a_busy[2], a_err[2];
    a_inta[0] = {7'd0, bus_a.INTA};         a_inta[1] = {7'd0, bus_b.INTA};
    a_vec[0]  = bus_a.vector;               a_vec[1]  = bus_b.vector;
    a_vv[0]   = {7'd0, bus_a.vector_valid}; a_vv[1]   = {7'd0, bus_b.vector_valid};
    a_busy[0] = {7'd0, bus_a.busy};         a_busy[1] = {7'd0, bus_b.busy};
    a_err[0]  = {7'd0, bus_a.timeout_err};  a_err[1]  = {7'd0, bus_b.timeout_err};
    for (int i = 0; i < 2; i++) begin
      chk("inta", i, a_inta[i], {7'd0, exp_inta(i)});
      chk("vector", i, a_vec[i], m_vec[i]);
      chk("vector_valid", i, a_vv[i], {7'd0, m_phase[i] == 2});
      chk("busy", i, a_busy[i], {7'd0, m_phase[i] != 0});
      chk("timeout_err", i, a_err[i], {7'd0, m_err[i]});
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
      check_all();
      if (rnd_data) data_i = 8'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_t0[i] = 0; m_rel[i] = 0; m_vec[i] = 8'h00; m_err[i] = 0;
    end

    // Reset state
    step(2);
    reset = 1'b0;
    step(2);

    // INT without IF_enable: no acknowledge
    int_i = 1'b1; if_i = 1'b0; rnd_data = 1'b1;
    step(20);

    // Nominal sequence, vector 4A, 10+ cycles in HOLD, early taken ignored
    int_i = 1'b0; step(1);
    rnd_data = 1'b0; data_i = 8'h4A;
    int_i = 1'b1; if_i = 1'b1;
    step(2);
    taken_i = 1'b1; step(1); taken_i = 1'b0;
    step(17);
    taken_i = 1'b1; step(1); taken_i = 1'b0;
    step(10);
    int_i = 1'b0; step(3);

    // Reset during ACK2 of the default-timing instance
    data_i = 8'hC3;
    int_i = 1'b1; step(1);
    step(4);
    reset = 1'b1; step(1);
    reset = 1'b0; int_i = 1'b0; step(3);

    // INT and IF_enable drop mid-sequence: spurious vector still captured
    rnd_data = 1'b1;
    int_i = 1'b1; step(1);
    int_i = 1'b0; if_i = 1'b0; step(10);
    taken_i = 1'b1; step(1); taken_i = 1'b0; step(2);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      int_i   = ($urandom_range(0, 3) != 0);
      if_i    = ($urandom_range(0, 1) != 0);
      taken_i = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 63) == 0);
      step(1);
    end
    reset = 1'b0; taken_i = 1'b0; int_i = 1'b0; step(3);

    // INT held after taken: watchdog fires only with the timeout build
    int_i = 1'b1; if_i = 1'b1; step(1);
    if_i = 1'b0; step(8);
    taken_i = 1'b1; step(1); taken_i = 1'b0;
    step(70);
    int_i = 1'b0; step(5);
    reset = 1'b1; step(1);
    reset = 1'b0; step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
